// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// with unsigned borrow, signed overflow and zero flags behind a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int IW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [WIDTH-1:0] res_full;
    logic [IW-1:0]    idx;
    logic             bin, a_msb, b_msb;
    logic             x, y, d, bout, last;

    // Single full-subtractor cell fed from the low end of the operand shifters.
    always_comb begin
        x        = a_sh[0];
        y        = b_sh[0];
        d        = x ^ y ^ bin;
        bout     = (~x & y) | (~x & bin) | (y & bin);
        last     = (idx == LAST);
        res_full = {d, res[WIDTH-1:1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Results are loaded on the final RUN edge so they are visible together with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            idx    <= '0;
            bin    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        bin   <= 1'b0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_full;
                    bin  <= bout;
                    if (!last) idx <= idx + 1'b1;
                    if (last) begin
                        diff   <= res_full;
                        borrow <= bout;
                        ovf    <= (a_msb != b_msb) && (res_full[WIDTH-1] != a_msb);
                        zero   <= ~|res_full;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, start8 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       busy4, done4, borrow4, ovf4, zero4;
    logic       busy8, done8, borrow8, ovf8, zero8;

    int n_checks = 0;
    int n_fail   = 0;
    int prev4    = 0;
    int prev8    = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4),
        .borrow(borrow4), .ovf(ovf4), .zero(zero4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8),
        .borrow(borrow8), .ovf(ovf8), .zero(zero8)
    );

    function automatic int model_diff(input int w, input int av, input int bv);
        return (av - bv) & ((1 << w) - 1);
    endfunction

    function automatic bit model_borrow(input int av, input int bv);
        return av < bv;
    endfunction

    function automatic bit model_ovf(input int w, input int av, input int bv);
        int half, sa, sb, r;
        half = 1 << (w - 1);
        sa = (av >= half) ? av - (1 << w) : av;
        sb = (bv >= half) ? bv - (1 << w) : bv;
        r  = sa - sb;
        return (r < -half) || (r >= half);
    endfunction

    function automatic bit obs_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic bit obs_done(input bit w8);
        return w8 ? done8 : done4;
    endfunction

    function automatic int obs_diff(input bit w8);
        return w8 ? int'(diff8) : int'(diff4);
    endfunction

    task automatic drive(input bit w8, input int av, input int bv, input bit s);
        if (w8) begin
            a8 = av[7:0]; b8 = bv[7:0]; start8 = s;
        end else begin
            a4 = av[3:0]; b4 = bv[3:0]; start4 = s;
        end
    endtask

    // Issues one request and follows it to its done cycle; called just after an active edge.
    task automatic run_op(input bit w8, input int av, input int bv, input bit hold,
                          output int d, output bit bo, output bit ov, output bit z,
                          output int lat, output int waits, output int extra,
                          output int gaps, output int held);
        bit acc;
        int prev;
        prev  = w8 ? prev8 : prev4;
        acc   = 1'b0;
        waits = 0; extra = 0; gaps = 0; held = 0; lat = 0;
        d = 0; bo = 1'b0; ov = 1'b0; z = 1'b0;
        drive(w8, av, bv, 1'b1);
        while (!acc && waits < 8) begin
            @(posedge clk); #1;
            waits++;
            if (obs_done(w8)) extra++;
            if (obs_busy(w8) && !obs_done(w8)) acc = 1'b1;
        end
        if (hold) drive(w8, 1, 1, 1'b1);
        else      drive(w8, int'($urandom), int'($urandom), 1'b0);
        if (acc) begin
            lat = 1;
            while (!obs_done(w8) && lat < 16) begin
                if (!obs_busy(w8)) gaps++;
                if (obs_diff(w8) != prev) held++;
                @(posedge clk); #1;
                lat++;
            end
            if (obs_done(w8)) begin
                if (!obs_busy(w8)) gaps++;
                d  = obs_diff(w8);
                bo = w8 ? borrow8 : borrow4;
                ov = w8 ? ovf8 : ovf4;
                z  = w8 ? zero8 : zero4;
            end else begin
                lat = 0;
            end
        end
    endtask

    task automatic test_reset;
        int lat;
        drive(1'b0, 9, 3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy4, done4, diff4, borrow4, ovf4, zero4} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset4 got busy=%b done=%b diff=%h borrow=%b ovf=%b zero=%b required all 0",
                     busy4, done4, diff4, borrow4, ovf4, zero4);
        end
        n_checks++;
        if ({busy8, done8, diff8, borrow8, ovf8, zero8} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset8 got busy=%b done=%b diff=%h borrow=%b ovf=%b zero=%b required all 0",
                     busy8, done8, diff8, borrow8, ovf8, zero8);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL start_at_reset_release got busy=%b required 1", busy4);
        end
        start4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != 5 || diff4 !== 4'd6) begin
            n_fail++;
            $display("FAIL release_op got latency=%0d diff=%0d required latency=5 diff=6", lat, diff4);
        end
        prev4 = 6;
    endtask

    task automatic test_basic;
        int d, lat, waits, extra, gaps, held;
        bit bo, ov, z;
        run_op(1'b0, 9, 3, 1'b0, d, bo, ov, z, lat, waits, extra, gaps, held);
        n_checks++;
        if (d != 6 || bo !== 1'b0 || ov !== model_ovf(4, 9, 3) || z !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result got diff=%0d borrow=%b ovf=%b zero=%b required diff=6 borrow=0 ovf=%b zero=0",
                     d, bo, ov, z, model_ovf(4, 9, 3));
        end
        n_checks++;
        if (lat != 5 || gaps != 0 || held != 0 || extra != 0) begin
            n_fail++;
            $display("FAIL basic_timing got latency=%0d busy_gaps=%0d held_err=%0d extra_done=%0d required 5/0/0/0",
                     lat, gaps, held, extra);
        end
        prev4 = 6;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 4'd6) begin
            n_fail++;
            $display("FAIL basic_hold got busy=%b done=%b diff=%0d required busy=0 done=0 diff=6",
                     busy4, done4, diff4);
        end
    endtask

    task automatic test_borrow_ovf;
        int d, lat, waits, extra, gaps, held;
        bit bo, ov, z;
        run_op(1'b0, 3, 9, 1'b0, d, bo, ov, z, lat, waits, extra, gaps, held);
        n_checks++;
        if (d != 10 || bo !== 1'b1 || ov !== 1'b1 || z !== 1'b0 || lat != 5 || waits != 1) begin
            n_fail++;
            $display("FAIL borrow_ovf got diff=%0d borrow=%b ovf=%b zero=%b latency=%0d wait=%0d required 10/1/1/0/5/1",
                     d, bo, ov, z, lat, waits);
        end
        prev4 = 10;
    endtask

    task automatic test_zero_negovf;
        int d, lat, waits, extra, gaps, held;
        bit bo, ov, z;
        run_op(1'b0, 5, 5, 1'b0, d, bo, ov, z, lat, waits, extra, gaps, held);
        n_checks++;
        if (d != 0 || bo !== 1'b0 || ov !== 1'b0 || z !== 1'b1 || lat != 5) begin
            n_fail++;
            $display("FAIL zero_result got diff=%0d borrow=%b ovf=%b zero=%b latency=%0d required 0/0/0/1/5",
                     d, bo, ov, z, lat);
        end
        prev4 = 0;
        run_op(1'b0, 8, 1, 1'b0, d, bo, ov, z, lat, waits, extra, gaps, held);
        n_checks++;
        if (d != 7 || bo !== 1'b0 || ov !== 1'b1 || z !== 1'b0 || lat != 5 || waits != 2) begin
            n_fail++;
            $display("FAIL neg_ovf got diff=%0d borrow=%b ovf=%b zero=%b latency=%0d wait=%0d required 7/0/1/0/5/2",
                     d, bo, ov, z, lat, waits);
        end
        prev4 = 7;
    endtask

    task automatic test_ignored_start;
        int d, lat, waits, extra, gaps, held;
        bit bo, ov, z;
        run_op(1'b0, 7, 15, 1'b1, d, bo, ov, z, lat, waits, extra, gaps, held);
        n_checks++;
        if (d != 8 || bo !== 1'b1 || ov !== 1'b1 || z !== 1'b0 || lat != 5 || held != 0) begin
            n_fail++;
            $display("FAIL ignored_start_op got diff=%0d borrow=%b ovf=%b zero=%b latency=%0d held_err=%0d required 8/1/1/0/5/0",
                     d, bo, ov, z, lat, held);
        end
        prev4 = 8;
        run_op(1'b0, 1, 1, 1'b0, d, bo, ov, z, lat, waits, extra, gaps, held);
        n_checks++;
        if (extra != 0 || waits != 2) begin
            n_fail++;
            $display("FAIL ignored_start_queue got extra_done=%0d wait=%0d required 0 and 2", extra, waits);
        end
        n_checks++;
        if (d != 0 || z !== 1'b1 || bo !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_next got diff=%0d zero=%b borrow=%b ovf=%b required 0/1/0/0", d, z, bo, ov);
        end
        prev4 = 0;
    endtask

    task automatic test_reset_mid;
        int d, lat, waits, extra, gaps, held, dones;
        bit bo, ov, z;
        run_op(1'b0, 9, 3, 1'b0, d, bo, ov, z, lat, waits, extra, gaps, held);
        prev4 = 6;
        drive(1'b0, 12, 5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        start4 = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy4, done4, diff4, borrow4, ovf4, zero4} !== 9'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async got busy=%b done=%b diff=%h borrow=%b ovf=%b zero=%b required all 0",
                     busy4, done4, diff4, borrow4, ovf4, zero4);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done4 || busy4) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL mid_reset_abort got %0d busy/done cycles required 0", dones);
        end
        prev4 = 0;
        prev8 = 0;
        run_op(1'b0, 4, 2, 1'b0, d, bo, ov, z, lat, waits, extra, gaps, held);
        n_checks++;
        if (d != 2 || bo !== 1'b0 || ov !== 1'b0 || z !== 1'b0 || lat != 5 || held != 0) begin
            n_fail++;
            $display("FAIL post_reset_op got diff=%0d borrow=%b ovf=%b zero=%b latency=%0d held_err=%0d required 2/0/0/0/5/0",
                     d, bo, ov, z, lat, held);
        end
        prev4 = 2;
    endtask

    task automatic test_sweep4;
        int d, lat, waits, extra, gaps, held, ed;
        bit bo, ov, z, eb, eo, ez;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(1'b0, i, j, 1'b0, d, bo, ov, z, lat, waits, extra, gaps, held);
                ed = model_diff(4, i, j);
                eb = model_borrow(i, j);
                eo = model_ovf(4, i, j);
                ez = (ed == 0);
                n_checks++;
                if (d != ed || bo !== eb || ov !== eo || z !== ez) begin
                    n_fail++;
                    $display("FAIL sweep4 a=%0d b=%0d got diff=%0d borrow=%b ovf=%b zero=%b required diff=%0d borrow=%b ovf=%b zero=%b",
                             i, j, d, bo, ov, z, ed, eb, eo, ez);
                end
                n_checks++;
                if (lat != 5 || waits != 2 || extra != 0 || gaps != 0 || held != 0) begin
                    n_fail++;
                    $display("FAIL sweep4_timing a=%0d b=%0d got latency=%0d wait=%0d extra=%0d gaps=%0d held_err=%0d required 5/2/0/0/0",
                             i, j, lat, waits, extra, gaps, held);
                end
                prev4 = ed;
            end
        end
    endtask

    task automatic test_random8;
        int d, lat, waits, extra, gaps, held, ed, av, bv;
        bit bo, ov, z, eb, eo, ez;
        for (int k = 0; k < 150; k++) begin
            av = int'($urandom_range(255, 0));
            bv = (k % 10 == 0) ? av : int'($urandom_range(255, 0));
            run_op(1'b1, av, bv, 1'b0, d, bo, ov, z, lat, waits, extra, gaps, held);
            ed = model_diff(8, av, bv);
            eb = model_borrow(av, bv);
            eo = model_ovf(8, av, bv);
            ez = (ed == 0);
            n_checks++;
            if (d != ed || bo !== eb || ov !== eo || z !== ez) begin
                n_fail++;
                $display("FAIL random8 a=%0d b=%0d got diff=%0d borrow=%b ovf=%b zero=%b required diff=%0d borrow=%b ovf=%b zero=%b",
                         av, bv, d, bo, ov, z, ed, eb, eo, ez);
            end
            n_checks++;
            if (lat != 9 || waits != ((k == 0) ? 1 : 2) || extra != 0 || gaps != 0 || held != 0) begin
                n_fail++;
                $display("FAIL random8_timing a=%0d b=%0d got latency=%0d wait=%0d extra=%0d gaps=%0d held_err=%0d required 9/%0d/0/0/0",
                         av, bv, lat, waits, extra, gaps, held, (k == 0) ? 1 : 2);
            end
            prev8 = ed;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_borrow_ovf;
        test_zero_negovf;
        test_ignored_start;
        test_reset_mid;
        test_sweep4;
        test_random8;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
